// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory bus.
// Register map (addr[3:2]): 0 TXDATA (write-only), 1 STATUS, 2 DIVISOR, 3 reserved.
// Bytes pushed to TXDATA go through a circular FIFO and are sent LSB first.
// Bus handshake: a write takes effect at the rising edge where ce=1 and we=1.
// A read returns data combinationally while ce=1 and we=0. There is no stall and no ready.
module mmio_uart_tx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_DEFAULT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx
);

    localparam int         PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0]  DEPTH_C = 5'(FIFO_DEPTH);
    localparam logic [15:0] DIV_RST = 16'(DIV_DEFAULT);

    // state_q is the FSM's observable state. busy is derived from it.
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e         state_q, state_d;
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]     count_q, count_d;
    logic           ovf_q, ovf_d;
    logic [15:0]    div_q, div_d;
    logic [15:0]    bit_div_q, bit_div_d;
    logic [15:0]    clk_cnt_q, clk_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;

    logic [1:0]     reg_sel;
    logic           wr_en, push_req, push_ok, push_drop, ovf_clr, div_wr;
    logic           full, empty, busy, pop, bit_done;
    logic           unused_bits;

    assign reg_sel   = addr[3:2];
    assign wr_en     = ce && we;
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == 5'd0);
    assign push_req  = wr_en && (reg_sel == 2'd0) && sel[0];
    assign push_ok   = push_req && !full;
    assign push_drop = push_req && full;
    assign ovf_clr   = wr_en && (reg_sel == 2'd1) && sel[0] && data_i[3];
    assign div_wr    = wr_en && (reg_sel == 2'd2) && (sel[1:0] == 2'b11);
    assign bit_done  = (clk_cnt_q == (bit_div_q - 16'd1));
    assign tx        = tx_q;
    assign unused_bits = ^{addr[31:4], addr[1:0], sel[3:2], data_i[31:16]};

    // State register and all datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= 5'd0;
            ovf_q     <= 1'b0;
            div_q     <= DIV_RST;
            bit_div_q <= DIV_RST;
            clk_cnt_q <= 16'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            div_q     <= div_d;
            bit_div_q <= bit_div_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // FIFO storage is not reset. Only the pointers and the count define its contents.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i[7:0];
    end

    // Next-state logic. A pop happens whenever a frame is launched.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d = S_START;
                    pop     = 1'b1;
                end
            end
            S_START: if (bit_done) state_d = S_DATA;
            S_DATA:  if (bit_done && (bit_cnt_q == 3'd7)) state_d = S_STOP;
            S_STOP: begin
                if (bit_done) begin
                    if (!empty) begin
                        state_d = S_START;
                        pop     = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bit timing and shift register. The divisor is latched per frame, so mid-frame writes wait.
    always_comb begin
        clk_cnt_d = (state_q == S_IDLE) ? 16'd0 : clk_cnt_q + 16'd1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        bit_div_d = bit_div_q;
        if (pop) begin
            shift_d   = mem_q[rd_ptr_q];
            bit_div_d = div_q;
            clk_cnt_d = 16'd0;
            bit_cnt_d = 3'd0;
        end else if (bit_done) begin
            case (state_q)
                S_START: begin
                    clk_cnt_d = 16'd0;
                    bit_cnt_d = 3'd0;
                end
                S_DATA: begin
                    clk_cnt_d = 16'd0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                S_STOP:  clk_cnt_d = 16'd0;
                default: clk_cnt_d = 16'd0;
            endcase
        end
    end

    // Outputs. tx is computed from the next state so the line is registered with no extra lag.
    always_comb begin
        busy = (state_q != S_IDLE);
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // FIFO pointers and count, the sticky overflow flag (set beats clear), and the divisor register.
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
        ovf_d = push_drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
        div_d = div_q;
        if (div_wr) div_d = (data_i[15:0] == 16'd0) ? 16'd1 : data_i[15:0];
    end

    // Read mux. It returns zero unless a read is active, and also while reset is asserted.
    always_comb begin
        data_o = 32'h0;
        if (ce && !we && !rst) begin
            case (reg_sel)
                2'd1:    data_o = {23'd0, count_q, ovf_q, busy, empty, full};
                2'd2:    data_o = {16'd0, div_q};
                default: data_o = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx. Each scenario task drives the bus and checks tx and the registers.
module tb_mmio_uart_tx;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        tx;

    int checks = 0;
    int errors = 0;

    mmio_uart_tx #(.FIFO_DEPTH(8), .DIV_DEFAULT(868)) dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
        .data_i(data_i), .data_o(data_o), .tx(tx)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks. A write lands on the posedge after the negedge where it is set up.
    task automatic bus_write(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        ce = 1'b1; we = 1'b1; addr = {28'hA5A5_000, r, 2'b11}; sel = s; data_i = d;
        @(posedge clk);
        #1;
        ce = 1'b0; we = 1'b0; sel = 4'h0; data_i = 32'h0;
    endtask

    task automatic peek(input logic [1:0] r, output logic [31:0] d);
        ce = 1'b1; we = 1'b0; addr = {28'h5A5A_FFF, r, 2'b00};
        #1;
        d = data_o;
        ce = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
        @(negedge clk);
        peek(r, d);
    endtask

    // Expected line level at clock t of a frame with 'div' clocks per bit.
    function automatic logic exp_bit(input logic [7:0] b, input int t, input int div);
        int idx;
        idx = t / div;
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    task automatic test_reset;
        logic [31:0] d;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        peek(2'd1, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_read_in_rst got %h exp %h", d, 32'h0); end
        @(negedge clk);
        rst = 1'b0;
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL reset_status got %h exp %h", d, 32'h2); end
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'd868) begin errors++; $display("FAIL reset_divisor got %0d exp 868", d); end
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
        addr = 32'h4; ce = 1'b0; we = 1'b0;
        #1;
        checks++;
        if (data_o !== 32'h0) begin errors++; $display("FAIL reset_ce0_data got %h exp 0", data_o); end
    endtask

    task automatic test_frame;
        logic [31:0] d;
        logic etx, ebusy;
        bus_write(2'd2, 32'd4, 4'b1111);
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'd4) begin errors++; $display("FAIL frame_div_rb got %0d exp 4", d); end
        bus_write(2'd0, 32'hA5, 4'b1111);
        for (int j = 0; j <= 41; j++) begin
            @(negedge clk);
            peek(2'd1, d);
            etx   = (j >= 1 && j <= 40) ? exp_bit(8'hA5, j - 1, 4) : 1'b1;
            ebusy = (j >= 1 && j <= 40);
            checks++;
            if (tx !== etx) begin errors++; $display("FAIL frame_tx j=%0d got %b exp %b", j, tx, etx); end
            checks++;
            if (d[2] !== ebusy) begin errors++; $display("FAIL frame_busy j=%0d got %b exp %b", j, d[2], ebusy); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        logic [7:0] bytes [3];
        logic etx;
        bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
        bus_write(2'd0, 32'h01, 4'b0001);
        bus_write(2'd0, 32'h02, 4'b0001);
        bus_write(2'd0, 32'h03, 4'b0001);
        // m counts edges since the first byte was popped (one edge after the first write).
        for (int m = 1; m <= 121; m++) begin
            @(negedge clk);
            peek(2'd1, d);
            etx = (m < 120) ? exp_bit(bytes[m / 40], m % 40, 4) : 1'b1;
            checks++;
            if (tx !== etx) begin errors++; $display("FAIL b2b_tx m=%0d got %b exp %b", m, tx, etx); end
            if (m == 1 || m == 40 || m == 80) begin
                checks++;
                if (d[8:4] !== 5'(2 - m / 40)) begin
                    errors++; $display("FAIL b2b_count m=%0d got %0d exp %0d", m, d[8:4], 2 - m / 40);
                end
            end
            if (m == 119 || m == 120) begin
                checks++;
                if (d[2] !== (m == 119)) begin errors++; $display("FAIL b2b_busy m=%0d got %b", m, d[2]); end
            end
        end
    endtask

    task automatic test_divisor_zero;
        logic [31:0] d;
        logic etx;
        bus_write(2'd2, 32'h0, 4'b1111);
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL div0_rb got %0d exp 1", d); end
        bus_write(2'd2, 32'h55, 4'b0001);
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL div_partial_sel got %0d exp 1", d); end
        bus_write(2'd0, 32'h5A, 4'b0001);
        for (int j = 0; j <= 11; j++) begin
            @(negedge clk);
            peek(2'd1, d);
            etx = (j >= 1 && j <= 10) ? exp_bit(8'h5A, j - 1, 1) : 1'b1;
            checks++;
            if (tx !== etx) begin errors++; $display("FAIL div0_tx j=%0d got %b exp %b", j, tx, etx); end
            checks++;
            if (d[2] !== (j >= 1 && j <= 10)) begin errors++; $display("FAIL div0_busy j=%0d got %b", j, d[2]); end
        end
        bus_write(2'd0, 32'h77, 4'b1110);
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL txdata_nosel got %h exp %h", d, 32'h2); end
        bus_write(2'd3, 32'hFFFF_FFFF, 4'b1111);
        bus_read(2'd3, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reserved_rd got %h exp 0", d); end
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL txdata_rd got %h exp 0", d); end
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        bus_write(2'd2, 32'hFFFF, 4'b0011);
        for (int i = 0; i < 9; i++) bus_write(2'd0, 32'(8'h10 + i), 4'b0001);
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h85) begin errors++; $display("FAIL ovf_full got %h exp %h", d, 32'h85); end
        bus_write(2'd0, 32'hEE, 4'b0001);
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h8D) begin errors++; $display("FAIL ovf_set got %h exp %h", d, 32'h8D); end
        bus_write(2'd1, 32'h8, 4'b1110);
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h8D) begin errors++; $display("FAIL ovf_clr_nosel got %h exp %h", d, 32'h8D); end
        bus_write(2'd1, 32'h8, 4'b0001);
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h85) begin errors++; $display("FAIL ovf_clr got %h exp %h", d, 32'h85); end
    endtask

    task automatic test_midframe_reset;
        logic [31:0] d;
        logic etx;
        // Clear the stalled FSM left by the overflow scenario.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_write(2'd0, 32'h35, 4'b0001);
        // Land in the middle of data bit 3 (0x35 bit 3 is 0).
        repeat (1 + 1 + 4 * 868 + 434) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL mid_bit3 got %b exp 0", tx); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL mid_async_tx got %b exp 1", tx); end
        peek(2'd1, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL mid_read_in_rst got %h exp 0", d); end
        @(negedge clk);
        rst = 1'b0;
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL mid_status got %h exp %h", d, 32'h2); end
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'd868) begin errors++; $display("FAIL mid_divisor got %0d exp 868", d); end
        bus_write(2'd0, 32'h96, 4'b1111);
        for (int j = 0; j <= 8681; j++) begin
            @(negedge clk);
            if (j >= 1 && j <= 8680 && ((j - 1) % 868) == 434) begin
                etx = exp_bit(8'h96, j - 1, 868);
                checks++;
                if (tx !== etx) begin errors++; $display("FAIL post_rst_tx j=%0d got %b exp %b", j, tx, etx); end
            end
            if (j == 8680 || j == 8681) begin
                peek(2'd1, d);
                checks++;
                if (d[2] !== (j == 8680)) begin errors++; $display("FAIL post_rst_busy j=%0d got %b", j, d[2]); end
            end
        end
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL post_rst_idle got %b exp 1", tx); end
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; we = 1'b0; addr = 32'h0; sel = 4'h0; data_i = 32'h0;
        test_reset;
        test_frame;
        test_back_to_back;
        test_divisor_zero;
        test_overflow;
        test_midframe_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
